ssram_master: RTL and testbench

// - Initiator side of the 8-bit-address / 16-bit-data ssram bus (ssram_we, ssram_re, ssram_addr, inout ssram_data).
// - Turns a valid/ready request (read or write) into one timed bus cycle with setup, strobe and hold phases.
// - Returns a single-cycle response that carries the read data or acknowledges the write.
// - Sits between a host/CPU bridge or test sequencer and the hwag ssram responder; one transaction in flight.

---
 rtl/ssram_master.sv | 106 ++++++++++
 tb/tb_ssram_master.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ssram_master.sv
// ssram bus initiator: one valid/ready request becomes a SETUP/STROBE/HOLD bus cycle; rsp_valid follows the accept by SETUP_CYC+STROBE_CYC cycles.
// req_ready is low from accept until HOLD ends, so only one transaction is ever in flight.
module ssram_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ssram_we,
  output logic                  ssram_re,
  output logic [ADDR_WIDTH-1:0] ssram_addr,
  inout  wire  [DATA_WIDTH-1:0] ssram_data
);

  if (SETUP_CYC < 1 || SETUP_CYC > 15 || STROBE_CYC < 1 || STROBE_CYC > 15 ||
      HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_timing
    $error("ssram_master: SETUP_CYC/STROBE_CYC/HOLD_CYC must be within 1..15");
  end

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  drive;

  assign ssram_data = drive ? wdata_q : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      drive      <= 1'b0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      ssram_we   <= 1'b0;
      ssram_re   <= 1'b0;
      ssram_addr <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            write_q    <= req_write;
            wdata_q    <= req_wdata;
            ssram_addr <= req_addr;
            drive      <= req_write;
            req_ready  <= 1'b0;
            cnt        <= 4'(SETUP_CYC - 1);
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == 4'd0) begin
            ssram_we <= write_q;
            ssram_re <= !write_q;
            cnt      <= 4'(STROBE_CYC - 1);
            state    <= STROBE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        STROBE: begin
          if (cnt == 4'd0) begin
            // Last strobe cycle: the responder's read data is valid on this edge.
            if (!write_q) begin
              rsp_rdata <= ssram_data;
            end
            ssram_we  <= 1'b0;
            ssram_re  <= 1'b0;
            rsp_valid <= 1'b1;
            cnt       <= 4'(HOLD_CYC - 1);
            state     <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (cnt == 4'd0) begin
            drive     <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ssram_master.sv
// Bench for ssram_master: phase-arithmetic model plus ssram responder, per-cycle compare, directed literal checks.
module tb_ssram_master;

  localparam int S  = 1;
  localparam int ST = 2;
  localparam int H  = 1;
  localparam logic [15:0] PROBE = 16'h5A5A;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        ssram_we, ssram_re;
  logic [7:0]  ssram_addr;
  wire  [15:0] ssram_data;

  logic        req_valid2, req_ready2, req_write2;
  logic [7:0]  req_addr2;
  logic [15:0] req_wdata2;
  logic        rsp_valid2;
  logic [15:0] rsp_rdata2;
  logic        ssram_we2, ssram_re2;
  logic [7:0]  ssram_addr2;
  wire  [15:0] ssram_data2;

  logic [15:0] drv = PROBE;
  bit          drv_en = 1'b1;
  bit          drv2_en = 1'b1;
  assign ssram_data  = drv_en ? drv : 16'bz;
  assign ssram_data2 = drv2_en ? 16'hBEEF : 16'bz;

  always #5 clk = ~clk;

  ssram_master u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ssram_we(ssram_we),
    .ssram_re(ssram_re), .ssram_addr(ssram_addr), .ssram_data(ssram_data)
  );

  ssram_master #(.SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2)) u_slow (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_write(req_write2), .req_addr(req_addr2), .req_wdata(req_wdata2),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .ssram_we(ssram_we2),
    .ssram_re(ssram_re2), .ssram_addr(ssram_addr2), .ssram_data(ssram_data2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h, want %0h", nm, cyc, act, exp);
    end
  endtask

  // Model state: a transaction accepted at edge t0 occupies cycles 1..S+ST+H after it.
  int          cyc = 0;
  bit          seen_rst = 1'b0;
  bit          busy = 1'b0;
  int          t0 = 0;
  bit          w_m;
  logic [7:0]  a_m;
  logic [15:0] d_m;
  logic [7:0]  addr_m = 8'h00;
  logic [15:0] rdata_m = 16'h0000;
  logic [15:0] mem [256];
  int          n_acc = 0;
  int          last_acc = 0;

  initial for (int i = 0; i < 256; i++) mem[i] = {8'(i), ~8'(i)};

  always @(posedge clk) begin
    bit idle_now;
    int kk;
    int k;
    cyc++;
    if (rst) begin
      busy     = 1'b0;
      rdata_m  = 16'h0000;
      addr_m   = 8'h00;
      seen_rst = 1'b1;
    end else begin
      idle_now = !busy;
      kk = cyc - t0;
      if (busy && kk == S + ST) begin
        if (w_m) mem[a_m] = d_m;
        else     rdata_m = mem[a_m];
      end
      if (busy && kk == S + ST + H) busy = 1'b0;
      if (idle_now && req_valid) begin
        busy = 1'b1; t0 = cyc;
        w_m = req_write; a_m = req_addr; d_m = req_wdata; addr_m = req_addr;
        n_acc++; last_acc = cyc;
      end
    end
    #1;
    k = cyc - t0 + 1;
    if (busy && w_m) begin
      drv_en = 1'b0;
    end else begin
      drv_en = 1'b1;
      drv = (busy && k > S && k <= S + ST) ? mem[a_m] : PROBE;
    end
  end

  always @(negedge clk) begin
    int k;
    bit strb;
    if (seen_rst) begin
      k = cyc - t0 + 1;
      strb = busy && k > S && k <= S + ST;
      chk("req_ready", req_ready, !busy);
      chk("ssram_we", ssram_we, strb && w_m);
      chk("ssram_re", ssram_re, strb && !w_m);
      chk("rsp_valid", rsp_valid, busy && k == S + ST + 1);
      chk("ssram_addr", ssram_addr, addr_m);
      chk("rsp_rdata", rsp_rdata, rdata_m);
      chk("ssram_data", ssram_data, (busy && w_m) ? d_m : drv);
      if (ssram_we && ssram_re) chk("we_and_re", 1, 0);
    end
  end

  task automatic issue(input bit w, input logic [7:0] a, input logic [15:0] d, output int tacc);
    int n0;
    n0 = n_acc;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    tacc = -1;
    for (int i = 0; i < 60 && tacc < 0; i++) begin
      @(posedge clk); #1;
      if (n_acc != n0) tacc = last_acc;
    end
    if (tacc < 0) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_neg(input int ta, input int k);
    do @(negedge clk); while (cyc < ta + k - 1);
  endtask

  initial begin
    int ta, t1, t2, t3;
    int re_cnt, first_re, first_rsp, first_rdy, rd2;
    bit got;
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 16'h0000;
    req_valid2 = 1'b0; req_write2 = 1'b0; req_addr2 = 8'h00; req_wdata2 = 16'h0000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_we_re", {ssram_we, ssram_re}, 0);
    chk("rst_rsp", {rsp_valid, rsp_rdata}, 0);
    chk("rst_addr", ssram_addr, 0);
    chk("rst_bus", ssram_data, 16'h5A5A);

    issue(1'b1, 8'h25, 16'hA5C3, ta);
    req_valid = 1'b0;
    wait_neg(ta, 1); chk("wr_c1_bus", ssram_data, 16'hA5C3); chk("wr_c1_we", ssram_we, 0);
    wait_neg(ta, 2); chk("wr_c2_we", ssram_we, 1); chk("wr_c2_addr", ssram_addr, 8'h25);
    wait_neg(ta, 4); chk("wr_c4_rsp", rsp_valid, 1); chk("wr_c4_bus", ssram_data, 16'hA5C3);
    wait_neg(ta, 5); chk("wr_c5_ready", req_ready, 1); chk("wr_c5_bus", ssram_data, 16'h5A5A);

    issue(1'b0, 8'h25, 16'h0000, ta);
    req_valid = 1'b0;
    wait_neg(ta, 2); chk("rd_c2_re", ssram_re, 1); chk("rd_c2_we", ssram_we, 0);
    wait_neg(ta, 4); chk("rd_c4_rsp", rsp_valid, 1); chk("rd_c4_data", rsp_rdata, 16'hA5C3);

    issue(1'b1, 8'h01, 16'h1111, t1);
    issue(1'b0, 8'h01, 16'h0000, t2);
    issue(1'b1, 8'hFF, 16'hFFFF, t3);
    req_valid = 1'b0;
    chk("b2b_gap1", t2 - t1, 5);
    chk("b2b_gap2", t3 - t2, 5);
    wait_neg(t3, 5); chk("b2b_rdata", rsp_rdata, 16'h1111); chk("b2b_ready", req_ready, 1);

    issue(1'b1, 8'h40, 16'h1234, ta);
    req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_we", ssram_we, 0); chk("abort_ready", req_ready, 1);
    chk("abort_bus", ssram_data, 16'h5A5A); chk("abort_rsp_c3", rsp_valid, 0);
    @(negedge clk); chk("abort_rsp_c4", rsp_valid, 0);
    issue(1'b0, 8'h40, 16'h0000, ta);
    req_valid = 1'b0;
    wait_neg(ta, 4); chk("post_abort_rsp", rsp_valid, 1); chk("post_abort_data", rsp_rdata, 16'h40BF);

    for (int n = 0; n < 2000; n++) begin
      issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom), ta);
      if ($urandom_range(0, 1) == 1) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    req_valid = 1'b0;
    repeat (8) @(posedge clk);

    req_valid2 = 1'b1; req_write2 = 1'b0; req_addr2 = 8'h33; req_wdata2 = 16'h0000;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = req_ready2;
    end
    chk("slow_ready_idle", got, 1);
    @(posedge clk); #1 req_valid2 = 1'b0;
    re_cnt = 0; first_re = 0; first_rsp = 0; first_rdy = 0; rd2 = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ssram_re2) begin re_cnt++; if (first_re == 0) first_re = k; end
      if (rsp_valid2 && first_rsp == 0) begin first_rsp = k; rd2 = rsp_rdata2; end
      if (req_ready2 && first_rdy == 0) first_rdy = k;
      if (ssram_we2) chk("slow_we", ssram_we2, 0);
      if (ssram_data2 !== 16'hBEEF) chk("slow_bus", ssram_data2, 16'hBEEF);
    end
    chk("slow_re_cycles", re_cnt, 4);
    chk("slow_first_re", first_re, 4);
    chk("slow_rsp_cycle", first_rsp, 8);
    chk("slow_ready_cycle", first_rdy, 10);
    chk("slow_rdata", rd2, 16'hBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
